// File: rtl/uart_pkg.sv
// Shared types and header packing for the UART TX scheduler.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA
   } tx_sched_state_t;

   localparam int HDR_ID_W  = 3;
   localparam int HDR_LEN_W = 5;

   function automatic logic [7:0] hdr_pack(
      input logic [HDR_ID_W-1:0]  id,
      input logic [HDR_LEN_W-1:0] len_m1
   );
      return {id, len_m1};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick; search starts one past last_id.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          req,
   input  logic [HDR_ID_W-1:0]   last_id,
   output logic [HDR_ID_W-1:0]   winner_id,
   output logic                  any
);

   // Scan farthest offset first so the nearest requester overwrites.
   always_comb begin
      winner_id = '0;
      any       = 1'b0;
      for (int k = N; k >= 1; k--) begin
         for (int j = 0; j < N; j++) begin
            if (req[j] && (j == (int'(last_id) + k) % N)) begin
               winner_id = HDR_ID_W'(j);
               any       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler feeding the UART TX FIFO write port.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ*5-1:0]   req_len,
   input  logic [N_REQ*8-1:0]   src_data,
   input  logic [N_REQ-1:0]     src_valid,
   output logic [N_REQ-1:0]     src_ready,
   output logic [N_REQ-1:0]     done,
   output logic [7:0]           tx_data_in,
   output logic                 tx_wr_en,
   input  logic                 tx_full,
   output logic                 busy,
   output logic [HDR_ID_W-1:0]  grant_id
);

   tx_sched_state_t       state_q, state_d;
   logic [HDR_ID_W-1:0]   grant_q, grant_d;
   logic [HDR_LEN_W-1:0]  len_q, len_d;
   logic [HDR_ID_W-1:0]   last_q, last_d;

   logic [HDR_ID_W-1:0]   win_id;
   logic                  win_any;
   logic [HDR_LEN_W-1:0]  win_len;
   logic [7:0]            cur_data;
   logic                  cur_valid;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req       (req),
      .last_id   (last_q),
      .winner_id (win_id),
      .any       (win_any)
   );

   always_comb begin
      win_len   = '0;
      cur_data  = '0;
      cur_valid = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_id == HDR_ID_W'(i))
            win_len = req_len[5*i +: 5];
         if (grant_q == HDR_ID_W'(i)) begin
            cur_data  = src_data[8*i +: 8];
            cur_valid = src_valid[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      len_d      = len_q;
      last_d     = last_q;
      tx_data_in = '0;
      tx_wr_en   = 1'b0;
      src_ready  = '0;
      done       = '0;
      unique case (state_q)
         IDLE: begin
            if (win_any) begin
               grant_d = win_id;
               len_d   = win_len;
               state_d = HDR;
            end
         end
         HDR: begin
            tx_data_in = hdr_pack(grant_q, len_q);
            tx_wr_en   = !tx_full;
            if (!tx_full)
               state_d = DATA;
         end
         DATA: begin
            tx_data_in = cur_data;
            tx_wr_en   = cur_valid && !tx_full;
            for (int i = 0; i < N_REQ; i++) begin
               if (grant_q == HDR_ID_W'(i)) begin
                  src_ready[i] = !tx_full;
                  done[i]      = tx_wr_en && (len_q == '0);
               end
            end
            if (tx_wr_en) begin
               if (len_q == '0) begin
                  last_d  = grant_q;
                  state_d = IDLE;
               end else begin
                  len_d = len_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         len_q   <= '0;
         last_q  <= HDR_ID_W'(N_REQ-1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         len_q   <= len_d;
         last_q  <= last_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a packet-level scoreboard.
module tb_uart_tx_sched;

   localparam int N  = 4;
   localparam int MD = 4096;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*5-1:0] req_len;
   logic [N*8-1:0] src_data;
   logic [N-1:0]   src_valid;
   logic [N-1:0]   src_ready;
   logic [N-1:0]   done;
   logic [7:0]     tx_data_in;
   logic           tx_wr_en;
   logic           tx_full;
   logic           busy;
   logic [2:0]     grant_id;

   always #50 clk = ~clk;

   uart_tx_sched #(.N_REQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_len    (req_len),
      .src_data   (src_data),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .done       (done),
      .tx_data_in (tx_data_in),
      .tx_wr_en   (tx_wr_en),
      .tx_full    (tx_full),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   int checks   = 0;
   int failures = 0;

   // Per-source byte streams; tb_ptr is what the source offers now.
   logic [7:0] src_mem [N][MD];
   int         tb_ptr  [N];
   int         mptr    [N];
   bit         pend    [N];

   // Packet-level model: the bytes the current grant still owes.
   bit         m_busy;
   bit         m_hdr;
   int         m_id;
   int         m_last;
   logic [7:0] m_exp [$];

   int         cyc;
   int         hdr_cyc;
   int         done_cyc;
   logic [7:0] last_hdr;
   int         hdr_ids [$];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N*5-1:0] all_len(input logic [4:0] l);
      logic [N*5-1:0] v;
      for (int i = 0; i < N; i++) v[5*i +: 5] = l;
      return v;
   endfunction

   task automatic drive(input logic [N-1:0] r, input logic [N*5-1:0] l,
                        input logic f, input logic [N-1:0] v);
      req       = r;
      req_len   = l;
      tx_full   = f;
      src_valid = v;
      for (int i = 0; i < N; i++)
         src_data[8*i +: 8] = src_mem[i][tb_ptr[i] % MD];
   endtask

   task automatic monitor();
      logic         exp_wr;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_done;
      int           w;
      logic [4:0]   len;
      exp_wr   = m_busy && !tx_full && (m_hdr || src_valid[m_id]);
      exp_rdy  = (m_busy && !m_hdr && !tx_full) ? N'(1 << m_id) : '0;
      exp_done = (exp_wr && !m_hdr && m_exp.size() == 1) ? N'(1 << m_id) : '0;
      check("busy", 32'(busy), 32'(m_busy));
      if (m_busy) check("grant_id", 32'(grant_id), 32'(m_id));
      check("tx_wr_en", 32'(tx_wr_en), 32'(exp_wr));
      if (exp_wr) check("tx_data", 32'(tx_data_in), 32'(m_exp[0]));
      else if (!m_busy) check("idle_data", 32'(tx_data_in), 32'h0);
      check("src_ready", 32'(src_ready), 32'(exp_rdy));
      check("done", 32'(done), 32'(exp_done));
      if (tx_wr_en && exp_wr && m_hdr) begin
         hdr_cyc  = cyc;
         last_hdr = tx_data_in;
         hdr_ids.push_back(int'(tx_data_in[7:5]));
      end
      if (done != '0) done_cyc = cyc;
      for (int i = 0; i < N; i++) pend[i] = src_valid[i] && src_ready[i];
      if (exp_wr) begin
         void'(m_exp.pop_front());
         m_hdr = 1'b0;
         if (m_exp.size() == 0) begin
            m_busy = 1'b0;
            m_last = m_id;
         end
      end else if (!m_busy && req != '0) begin
         w = 0;
         for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) begin
               w = (m_last + k) % N;
               break;
            end
         end
         len = req_len[5*w +: 5];
         m_exp.delete();
         m_exp.push_back({3'(w), len});
         for (int j = 0; j <= int'(len); j++)
            m_exp.push_back(src_mem[w][(mptr[w] + j) % MD]);
         mptr[w] += int'(len) + 1;
         m_id   = w;
         m_busy = 1'b1;
         m_hdr  = 1'b1;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (pend[i]) tb_ptr[i]++;
         pend[i] = 1'b0;
      end
      cyc++;
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N*5-1:0] l,
                       input logic f, input logic [N-1:0] v);
      drive(r, l, f, v);
      @(negedge clk);
      monitor();
      advance();
   endtask

   initial begin
      bit found;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < MD; j++) src_mem[i][j] = 8'($urandom);
         tb_ptr[i] = 0;
         mptr[i]   = 0;
         pend[i]   = 1'b0;
      end
      m_busy = 1'b0;
      m_hdr  = 1'b0;
      m_id   = 0;
      m_last = N - 1;
      cyc    = 0;
      rst_n  = 1'b0;
      drive('0, '0, 1'b0, '0);
      #20;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_wr_en", 32'(tx_wr_en), 32'h0);
      check("rst_ready", 32'(src_ready), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_data", 32'(tx_data_in), 32'h0);
      check("rst_grant", 32'(grant_id), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single packet from requester 1, three payload bytes.
      step(4'b0010, 20'(5'd2) << 5, 1'b0, 4'b1111);
      for (int c = 0; c < 8; c++) step('0, '0, 1'b0, 4'b1111);
      check("single_hdr", 32'(last_hdr), 32'h22);
      check("single_done_lat", 32'(done_cyc - hdr_cyc), 32'd3);

      // Fairness with all requesters and zero-length payloads.
      hdr_ids.delete();
      for (int c = 0; c < 18; c++) step(4'b1111, '0, 1'b0, 4'b1111);
      for (int c = 0; c < 4; c++) step('0, '0, 1'b0, 4'b1111);
      check("fair_count", 32'(hdr_ids.size() >= 5), 32'h1);
      if (hdr_ids.size() >= 5) begin
         check("fair_first", 32'(hdr_ids[0]), 32'd2);
         for (int k = 0; k < 4; k++)
            check("fair_order", 32'(hdr_ids[k+1]), 32'((hdr_ids[k] + 1) % N));
      end

      // Random traffic with backpressure, stalls and changing lengths.
      for (int c = 0; c < 2000; c++)
         step(N'($urandom), (N*5)'($urandom), $urandom_range(0, 3) == 0,
              N'($urandom | $urandom));

      // Maximum-length packets, then reset in the middle of one.
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         step(N'($urandom_range(1, 15)), all_len(5'h1f),
              $urandom_range(0, 7) == 0, N'($urandom | $urandom));
         if (c > 150 && m_busy && !m_hdr && m_exp.size() >= 2) found = 1'b1;
      end
      check("rst_wait", 32'(found), 32'h1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_wr_en", 32'(tx_wr_en), 32'h0);
      check("arst_ready", 32'(src_ready), 32'h0);
      check("arst_done", 32'(done), 32'h0);
      check("arst_data", 32'(tx_data_in), 32'h0);
      check("arst_grant", 32'(grant_id), 32'h0);
      m_busy = 1'b0;
      m_hdr  = 1'b0;
      m_last = N - 1;
      m_exp.delete();
      for (int i = 0; i < N; i++) mptr[i] = tb_ptr[i];
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hdr_ids.delete();
      for (int c = 0; c < 3; c++)
         step(4'b1001, (N*5)'($urandom), 1'b0, 4'b1111);
      check("post_rst_hdrs", 32'(hdr_ids.size() >= 1), 32'h1);
      if (hdr_ids.size() >= 1)
         check("post_rst_first", 32'(hdr_ids[0]), 32'd0);
      for (int c = 0; c < 80; c++) step('0, '0, 1'b0, 4'b1111);
      check("final_idle", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
